// File: rtl/mod3_job_scheduler.sv
// Round-robin scheduler sharing one serial 64-bit mod-3 unit between NUM_REQ requesters.
// One job in flight at a time: grant, launch, run (with timeout), then hold the tagged response.
module mod3_job_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [64*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [1:0]              rsp_rem,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [63:0]             mod_x,
  output logic                    mod_e,
  input  logic [1:0]              mod_s,
  input  logic                    mod_f
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [63:0]       x_q, x_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        rem_q, rem_d;
  logic              err_q, err_d;

  logic              win_found;
  logic [ID_W-1:0]   win_idx;

  // Rotating priority search starting at rr_ptr_q.
  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      cand = ID_W'(idx);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && win_found) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    x_d      = x_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          x_d     = req_data[{win_idx, 6'd0} +: 64];
          id_d    = win_idx;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        // cnt_q == 0 marks the first RUN cycle, where a stale mod_f is not trusted.
        if (cnt_q != '0 && mod_f) begin
          rem_d   = mod_s;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rem_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      x_q      <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      x_q      <= x_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      err_q    <= err_d;
    end
  end

  assign mod_x     = x_q;
  assign mod_e     = (state_q == RUN);
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_rem   = rem_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != IDLE);

endmodule
